// File: rtl/vga_timing_pkg.sv
// Shared VGA timing header: default XGA 1024x768@60 constants and helpers
// used by vga_timing and the draw_* stages.
package vga_timing_pkg;

   localparam int CNT_W = 11;

   localparam int H_ACTIVE_DEF = 1024;
   localparam int H_FP_DEF     = 24;
   localparam int H_SYNC_DEF   = 136;
   localparam int H_BP_DEF     = 160;
   localparam int V_ACTIVE_DEF = 768;
   localparam int V_FP_DEF     = 3;
   localparam int V_SYNC_DEF   = 6;
   localparam int V_BP_DEF     = 29;

   localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
   localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
   localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

   function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   // Half-open window test [lo, hi) on an unsigned count.
   function automatic logic in_range(input logic [CNT_W-1:0] v, input int lo, input int hi);
      return ({21'd0, v} >= lo) && ({21'd0, v} < hi);
   endfunction

endpackage

// File: rtl/vga_counter.sv
// Modulo-N counter with a wrap strobe; count_d is the next value so the
// parent can decode flags that land in the same cycle as the count.
module vga_counter
   import vga_timing_pkg::*;
#(
   parameter int N = H_TOTAL,
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] count_q,
   output logic [W-1:0] count_d,
   output logic         wrap
);

   logic at_max;
   assign at_max = (count_q == W'(N - 1));

   always_comb begin
      count_d = count_q;
      wrap    = 1'b0;
      if (en) begin
         if (at_max) begin
            count_d = '0;
            wrap    = 1'b1;
         end else begin
            count_d = count_q + W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: chained h/v counters plus registered sync/blank flags
// decoded from the next-state counts so every output refers to one pixel.
module vga_timing
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
) (
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] hcount_out,
   output logic             hsync_out,
   output logic             hblnk_out,
   output logic [CNT_W-1:0] vcount_out,
   output logic             vsync_out,
   output logic             vblnk_out,
   output logic             frame_start
);

   localparam int H_TOT = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOT = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HS_LO = H_ACTIVE + H_FP;
   localparam int HS_HI = HS_LO + H_SYNC;
   localparam int VS_LO = V_ACTIVE + V_FP;
   localparam int VS_HI = VS_LO + V_SYNC;

   logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
   logic             h_wrap, v_wrap;

   logic hsync_q, hsync_d, hblnk_q, hblnk_d;
   logic vsync_q, vsync_d, vblnk_q, vblnk_d;
   logic frame_start_q, frame_start_d;

   vga_counter #(.N(H_TOT), .W(CNT_W)) u_hcnt (
      .clk     (clk),
      .rst     (rst),
      .en      (1'b1),
      .count_q (h_q),
      .count_d (h_d),
      .wrap    (h_wrap)
   );

   vga_counter #(.N(V_TOT), .W(CNT_W)) u_vcnt (
      .clk     (clk),
      .rst     (rst),
      .en      (h_wrap),
      .count_q (v_q),
      .count_d (v_d),
      .wrap    (v_wrap)
   );

   always_comb begin
      hblnk_d       = in_range(h_d, H_ACTIVE, H_TOT);
      hsync_d       = in_range(h_d, HS_LO, HS_HI);
      vblnk_d       = in_range(v_d, V_ACTIVE, V_TOT);
      vsync_d       = in_range(v_d, VS_LO, VS_HI);
      frame_start_d = (h_d == '0) && (v_d == '0);
   end

   // Reset lands on pixel (0,0), hence frame_start comes out of reset high.
   always_ff @(posedge clk) begin
      if (rst) begin
         hsync_q       <= 1'b0;
         hblnk_q       <= 1'b0;
         vsync_q       <= 1'b0;
         vblnk_q       <= 1'b0;
         frame_start_q <= 1'b1;
      end else begin
         hsync_q       <= hsync_d;
         hblnk_q       <= hblnk_d;
         vsync_q       <= vsync_d;
         vblnk_q       <= vblnk_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hcount_out  = h_q;
   assign vcount_out  = v_q;
   assign hsync_out   = hsync_q;
   assign hblnk_out   = hblnk_q;
   assign vsync_out   = vsync_q;
   assign vblnk_out   = vblnk_q;
   assign frame_start = frame_start_q;

   logic unused_v_wrap;
   assign unused_v_wrap = v_wrap;

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The block SHALL have the parameter H_ACTIVE, default 1024, meaning visible pixels per line.
REQ-002 The block SHALL have the parameter H_FP, default 24, meaning the horizontal front porch in pixels.
REQ-003 The block SHALL have the parameter H_SYNC, default 136, meaning the horizontal sync width in pixels.
REQ-004 The block SHALL have the parameter H_BP, default 160, meaning the horizontal back porch in pixels; H_TOTAL=1344.
REQ-005 The block SHALL have the parameter V_ACTIVE, default 768, meaning visible lines per frame.
REQ-006 The block SHALL have the parameter V_FP, default 3, meaning the vertical front porch in lines.
REQ-007 The block SHALL have the parameter V_SYNC, default 6, meaning the vertical sync width in lines.
REQ-008 The block SHALL have the parameter V_BP, default 29, meaning the vertical back porch in lines; V_TOTAL=806.
REQ-009 The block SHALL have the port clk, input, 1 bit: the pixel clock (65 MHz); the block uses one clock only.
REQ-010 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-011 The block SHALL have the port hcount_out, output, 11 bits: the pixel index within the line.
REQ-012 The block SHALL have the port hsync_out, output, 1 bit: horizontal sync, high during the sync interval.
REQ-013 The block SHALL have the port hblnk_out, output, 1 bit: horizontal blanking, high outside the active pixels.
REQ-014 The block SHALL have the port vcount_out, output, 11 bits: the line index within the frame.
REQ-015 The block SHALL have the port vsync_out, output, 1 bit: vertical sync, high during the sync interval.
REQ-016 The block SHALL have the port vblnk_out, output, 1 bit: vertical blanking, high outside the active lines.
REQ-017 The block SHALL have the port frame_start, output, 1 bit: a one-cycle pulse marking pixel (0,0).

Function
REQ-018 hcount_out SHALL increment by 1 on every clk edge with rst low, and wrap from H_TOTAL-1 (1343) to 0.
REQ-019 vcount_out SHALL increment only on the edge where hcount_out wraps, and SHALL wrap from V_TOTAL-1 (805) to 0 on that same edge.
REQ-020 vcount_out SHALL otherwise hold its value; no count SHALL ever reach H_TOTAL or V_TOTAL.
REQ-021 hblnk_out SHALL be 1 exactly when hcount_out is at least H_ACTIVE (1024..1343).
REQ-022 hsync_out SHALL be 1 exactly when hcount_out is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 1048..1183.
REQ-023 vblnk_out SHALL be 1 exactly when vcount_out is at least V_ACTIVE (768..805).
REQ-024 vsync_out SHALL be 1 exactly when vcount_out is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 771..776.
REQ-025 All outputs SHALL be registered and SHALL correspond to the same pixel, with zero skew between the counts and the flags.
REQ-026 To meet REQ-025, each flag SHALL be decoded from the next-state counter values.
REQ-027 frame_start SHALL be 1 in exactly the cycle in which hcount_out=0 and vcount_out=0, and 0 otherwise.
REQ-028 The frame period SHALL be exactly 1344*806 = 1,083,264 clk cycles, and the line period exactly 1344 cycles.
REQ-029 At the simultaneous wrap (hcount 1343 and vcount 805), the next cycle SHALL present (0,0) with all four flags 0 and frame_start 1.

Reset
REQ-030 While rst is high at a clk edge, hcount_out and vcount_out SHALL become 0, hsync/hblnk/vsync/vblnk SHALL become 0, and frame_start SHALL become 1.
REQ-031 Reset asserted mid-frame SHALL abandon the frame immediately, with no partial-sync completion.
REQ-032 On the first edge after rst falls, the outputs SHALL present hcount_out=1 and vcount_out=0 with frame_start=0.

Structure
REQ-033 The timing constants (H_/V_ values, H_TOTAL, V_TOTAL, and the derived sync start/end) SHALL live in the shared VGA parameter header.
REQ-034 draw_* stages SHALL use the same shared VGA parameter header.
REQ-035 One sub-module is natural, vga_counter: a parameterised modulo-N counter with wrap strobe, instantiated twice and chained through the wrap strobe.
REQ-036 The decode of the flags SHALL remain in vga_timing.

Verification
REQ-037 Scenario: rst held 3 cycles, then released -> counts 0,0 and flags 0 during reset; after release hcount_out is 1, 2, 3 ... and vcount_out stays 0.
REQ-038 Scenario: run one line -> hblnk rises at hcount 1024; hsync is high for 1048..1183 (136 cycles); at hcount 1343->0, vcount goes 0->1.
REQ-039 Scenario: run one frame -> vblnk is high for vcount 768..805; vsync is high for vcount 771..776 (6*1344 = 8064 cycles); frame_start pulses are 1,083,264 cycles apart.
REQ-040 Scenario: observe (1343,805) -> next cycle (0,0) with frame_start=1 and hsync=hblnk=vsync=vblnk=0.
REQ-041 Scenario: rst pulsed for 1 cycle at (1100,773), during both syncs -> next cycle (0,0) with all flags 0; the subsequent frame timing matches REQ-039.
REQ-042 Scenario: a checker run over 3 frames compares every output against a reference model, with zero mismatches and no count reaching 1344 or 806.
